// File: rtl/dcache_pkg.sv
// Shared encodings and field geometry for the direct-mapped, write-back data cache controller.
package dcache_pkg;
    localparam int unsigned BYTE_OFF_W     = 2;
    localparam int unsigned WORD_IDX_W     = 3;
    localparam int unsigned OFFSET_W       = BYTE_OFF_W + WORD_IDX_W;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned WORDS_PER_LINE = 1 << WORD_IDX_W;
    localparam int unsigned LINE_BITS      = WORD_W * WORDS_PER_LINE;
    localparam int unsigned TAG_BITS       = 23;
    localparam int unsigned VALID_BIT      = 24;
    localparam int unsigned DIRTY_BIT      = 23;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StRefill,
        StUpdate
    } state_e;
endpackage

// File: rtl/dcache_word_merge.sv
// Replaces one 32-bit word of a cache line; shared by store-hit and refill-update paths.
module dcache_word_merge
    import dcache_pkg::*;
#(
    parameter int unsigned LINE_W = LINE_BITS
) (
    input  logic [LINE_W-1:0]     line_i,
    input  logic [WORD_IDX_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0]     word_i,
    output logic [LINE_W-1:0]     line_o
);
    always_comb begin
        line_o = line_i;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (word_sel_i == WORD_IDX_W'(i)) begin
                line_o[i*WORD_W +: WORD_W] = word_i;
            end
        end
    end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller: hits complete combinationally in IDLE,
// misses optionally write back a dirty victim, refill from memory, then update the SRAM.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned LINE_W  = 256
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                cpu_req_i,
    input  logic                                cpu_write_i,
    input  logic [ADDR_W-1:0]                   cpu_addr_i,
    input  logic [WORD_W-1:0]                   cpu_data_i,
    output logic [WORD_W-1:0]                   cpu_data_o,
    output logic                                cpu_stall_o,
    output logic [INDEX_W-1:0]                  sram_addr_o,
    output logic [ADDR_W-INDEX_W-OFFSET_W+1:0]  sram_tag_o,
    output logic [LINE_W-1:0]                   sram_data_o,
    output logic                                sram_enable_o,
    output logic                                sram_write_o,
    input  logic [ADDR_W-INDEX_W-OFFSET_W+1:0]  sram_tag_i,
    input  logic [LINE_W-1:0]                   sram_data_i,
    input  logic                                sram_hit_i,
    output logic                                mem_enable_o,
    output logic                                mem_write_o,
    output logic [ADDR_W-1:0]                   mem_addr_o,
    output logic [LINE_W-1:0]                   mem_data_o,
    input  logic [LINE_W-1:0]                   mem_data_i,
    input  logic                                mem_ack_i
);
    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    state_e state_q, state_d;

    logic [TAG_W-1:0]      lat_tag_q, victim_tag_q;
    logic [INDEX_W-1:0]    lat_index_q;
    logic [WORD_IDX_W-1:0] lat_word_q;
    logic                  write_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [LINE_W-1:0]     victim_line_q, refill_q;

    logic [TAG_W-1:0]      cpu_tag;
    logic [INDEX_W-1:0]    cpu_index;
    logic [WORD_IDX_W-1:0] cpu_word;
    logic                  miss;
    logic [WORD_W-1:0]     rd_word;
    logic [LINE_W-1:0]     merge_src, merged;
    logic                  unused_byte_off;

    assign cpu_tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign cpu_index       = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign cpu_word        = cpu_addr_i[BYTE_OFF_W +: WORD_IDX_W];
    assign unused_byte_off = ^cpu_addr_i[BYTE_OFF_W-1:0];
    assign miss            = (state_q == StIdle) && cpu_req_i && !sram_hit_i;

    // One merger: live SRAM line on a store hit, latched refill line during UPDATE.
    assign merge_src = (state_q == StIdle) ? sram_data_i : refill_q;

    dcache_word_merge #(
        .LINE_W (LINE_W)
    ) u_merge (
        .line_i     (merge_src),
        .word_sel_i ((state_q == StIdle) ? cpu_word : lat_word_q),
        .word_i     ((state_q == StIdle) ? cpu_data_i : wdata_q),
        .line_o     (merged)
    );

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (cpu_word == WORD_IDX_W'(i)) begin
                rd_word = sram_data_i[i*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (miss) begin
                    state_d = (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT]) ? StWriteback
                                                                               : StRefill;
                end
            end
            StWriteback: if (mem_ack_i) state_d = StRefill;
            StRefill:    if (mem_ack_i) state_d = StUpdate;
            StUpdate:    state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lat_tag_q     <= '0;
            lat_index_q   <= '0;
            lat_word_q    <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            victim_tag_q  <= '0;
            victim_line_q <= '0;
            refill_q      <= '0;
        end else begin
            if (miss) begin
                lat_tag_q     <= cpu_tag;
                lat_index_q   <= cpu_index;
                lat_word_q    <= cpu_word;
                write_q       <= cpu_write_i;
                wdata_q       <= cpu_data_i;
                victim_tag_q  <= sram_tag_i[TAG_W-1:0];
                victim_line_q <= sram_data_i;
            end
            if (state_q == StRefill && mem_ack_i) begin
                refill_q <= mem_data_i;
            end
        end
    end

    // Outputs are forced low for as long as reset is held, independent of the clock.
    always_comb begin
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b0;
        sram_addr_o   = '0;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        if (rst_i) begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_req_i) begin
                        sram_enable_o           = 1'b1;
                        sram_addr_o             = cpu_index;
                        sram_tag_o[TAG_W-1:0]   = cpu_tag;
                        if (!sram_hit_i) begin
                            cpu_stall_o = 1'b1;
                        end else if (cpu_write_i) begin
                            sram_write_o          = 1'b1;
                            sram_tag_o[VALID_BIT] = 1'b1;
                            sram_tag_o[DIRTY_BIT] = 1'b1;
                            sram_data_o           = merged;
                        end else begin
                            cpu_data_o = rd_word;
                        end
                    end
                end
                StWriteback: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {victim_tag_q, lat_index_q, {OFFSET_W{1'b0}}};
                    mem_data_o   = victim_line_q;
                end
                StRefill: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {lat_tag_q, lat_index_q, {OFFSET_W{1'b0}}};
                end
                StUpdate: begin
                    cpu_stall_o   = 1'b1;
                    sram_enable_o = 1'b1;
                    sram_write_o  = 1'b1;
                    sram_addr_o   = lat_index_q;
                    sram_tag_o    = {1'b1, write_q, lat_tag_q};
                    sram_data_o   = write_q ? merged : refill_q;
                end
                default: ;
            endcase
        end
    end
endmodule
